beam_trigger_scaler: RTL and testbench
======================================

# beam_trigger_scaler

Per-beam trigger rate counter for the L1 trigger path, on the receiving end of the packed trigger stream. It unpacks the per-beam trigger bits from the 128-bit AXI4-Stream that the L1 trigger emits, counts rising edges per beam over a programmable gate, and latches the totals at gate end. It then serialises them as one 32-bit AXI4-Stream beat per beam, with backpressure, for the housekeeping/readout path.

## Interface

Parameters:
- NBEAMS, 2, number of beams decoded (1..96)
- CNT_BITS, 24, per-beam counter width (1..24)
- PERIOD_BITS, 27, gate timer width

Ports:
- Clocking (already decided): one clock, `aclk`; reset `reset_i` is asynchronous and active-high.
- aclk  in  1  sole clock; all logic rising-edge
- reset_i  in  1  async active-high reset
- trig_tdata  in  128  packed trigger stream; 8 lanes × 16 bits, payload in bits [15:4] of each lane
- trig_tvalid  in  1  beat qualifier; no tready, source never stalls
- enable_i  in  1  gate run enable
- period_i  in  PERIOD_BITS  gate length in aclk cycles minus 1
- overrun_clr_i  in  1  clears overrun_o
- scal_tdata  out  32  {beam index [31:24], count zero-extended [23:0]}
- scal_tvalid  out  1  readout beat valid
- scal_tready  in  1  downstream ready
- scal_tlast  out  1  final beam of a gate
- overrun_o  out  1  sticky: a gate ended while the previous readout was incomplete

## Operation

**Beam extraction**
- Beam b = trig_tdata[16*(b/12) + 4 + (b%12)].
- Bits [3:0] of each lane and beams ≥ NBEAMS are ignored.

**Edge detection**
- Per-beam prev register, reset 0, updated only on trig_tvalid beats.
- edge[b] = cur & ~prev, and counts only when trig_tvalid=1.

**Live counters**
- Increment on edge[b]; saturate at 2^CNT_BITS−1.

**Gate timer**
- enable_i=1: the timer increments each cycle.
- Terminal cycle is timer ≥ period_i (a period_i decrease below the current timer ends the gate next compare). On the terminal cycle:
  - timer ← 0
  - the gate-end strobe fires
  - live counters, including the terminal cycle's edge (saturating), are offered to the holding array
  - live counters ← 0
- enable_i=0: timer, live counters and prev are held at 0; no gate end occurs; a readout in progress completes.

**Readout FSM**
- IDLE: scal_tvalid=0. On an accepted gate end, load the holding array, set idx ← 0, go to SEND.
- SEND:
  - scal_tvalid=1; scal_tdata = {idx, hold[idx]}; scal_tlast = (idx == NBEAMS−1).
  - On tvalid&tready: idx+1; after the last beat, return to IDLE.
  - scal_tdata and scal_tlast are stable while tvalid & !tready.

**Simultaneous events**
- Gate end in SEND, not on the final handshake: the holding array is untouched, that gate's counts are discarded, overrun_o ← 1.
- Gate end on the same cycle as the final-beat handshake: accepted. Holding is reloaded, idx ← 0, the FSM stays in SEND, no overrun.
- overrun_o is cleared by overrun_clr_i unless an overrun occurs the same cycle (set wins).

## Timing

**Reset values**
- All outputs 0.
- FSM IDLE; timer, counters, prev and holding all 0.

**Latency**
- An edge on a tvalid beat at cycle n is visible in the live counter at n+1.
- Gate end at cycle T gives scal_tvalid=1 with idx 0 at T+1.

**Gate and readout length**
- Gate length is period_i+1 cycles.
- With tready held high, readout takes NBEAMS cycles. A readout therefore completes without overrun if NBEAMS ≤ period_i+1.

**Async reset**
- Asserting reset_i mid-SEND drops scal_tvalid immediately and clears all state.
- After reset deassertion, a fresh gate starts once enable_i=1.

## Test plan

1. **Basic counting**
   - Stimulus: NBEAMS=2, period_i=99, enable_i=1, tready=1. Beam0 one-cycle pulses every 10 cycles from gate start; beam1 held high.
   - Required: gate 1 beats 0x00_00000A and 0x01_000001 (tlast); gate 2 beats 0x00_00000A and 0x01_000000.
2. **Backpressure**
   - Stimulus: as test 1, tready=0 for 50 cycles after gate end.
   - Required: tvalid held, tdata=0x00_00000A stable throughout. Then tready=1 gives 2 consecutive beats, tlast on the second. overrun_o stays 0.
3. **Overrun**
   - Stimulus: NBEAMS=2, period_i=3, tready=0.
   - Required:
     - The second gate end sets overrun_o=1.
     - The first beat still shows gate-1 counts.
     - overrun_clr_i pulse gives overrun_o=0 next cycle.
4. **Saturation**
   - Stimulus: CNT_BITS=4, 20 edges within one gate.
   - Required: count 15.
5. **Beam mapping and tvalid gating**
   - Stimulus: NBEAMS=14; pulses only on trig_tdata[21] (beam 13), half of them on beats with trig_tvalid=0.
   - Required: only idx 13 is nonzero, counting tvalid=1 pulses only.
   - Stimulus: pulses on bit [3:0].
   - Required: no counts.
6. **Reset mid-readout**
   - Stimulus: assert reset_i during beat idx 1 of 2.
   - Required:
     - scal_tvalid=0 with no clock edge.
     - After release, the next gate's readout starts from idx 0 with counts only from the new gate.

Source files
------------

// File: rtl/beam_trigger_scaler.sv
// beam_trigger_scaler: per-beam trigger edge counters over a programmable gate, read out as one AXI4-Stream beat per beam
module beam_trigger_scaler #(
    parameter int NBEAMS      = 2,
    parameter int CNT_BITS    = 24,
    parameter int PERIOD_BITS = 27
) (
    input  logic                   aclk,
    input  logic                   reset_i,
    input  logic [127:0]           trig_tdata,
    input  logic                   trig_tvalid,
    input  logic                   enable_i,
    input  logic [PERIOD_BITS-1:0] period_i,
    input  logic                   overrun_clr_i,
    output logic [31:0]            scal_tdata,
    output logic                   scal_tvalid,
    input  logic                   scal_tready,
    output logic                   scal_tlast,
    output logic                   overrun_o
);
    localparam int IW = NBEAMS > 1 ? $clog2(NBEAMS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBEAMS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [PERIOD_BITS-1:0] timer_q;
    logic [NBEAMS-1:0]      cur, prev_q, edge_v;
    logic [CNT_BITS-1:0]    cnt_q   [NBEAMS];
    logic [CNT_BITS-1:0]    cnt_inc [NBEAMS];
    logic [CNT_BITS-1:0]    hold_q  [NBEAMS];
    logic                   gate_end, last, fin_hs, load, ovr_set, overrun_q;
    logic                   unused_lanes;

    // Only payload bits [15:4] of each lane carry beams; the rest is deliberately dropped
    assign unused_lanes = ^trig_tdata;

    genvar g;
    for (g = 0; g < NBEAMS; g++) begin : g_beam
        assign cur[g] = trig_tdata[16*(g/12) + 4 + (g%12)];
    end

    assign gate_end  = enable_i && timer_q >= period_i;
    assign overrun_o = overrun_q;

    // Rising-edge detect on valid beats and saturating increment, terminal-cycle edge included
    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            edge_v[b]  = trig_tvalid & cur[b] & ~prev_q[b];
            cnt_inc[b] = (edge_v[b] && cnt_q[b] != CNT_MAX) ? cnt_q[b] + CNT_BITS'(1) : cnt_q[b];
        end
    end

    // Gate timer, edge history and live counters; everything sits at zero while disabled
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            timer_q <= '0;
            prev_q  <= '0;
            for (int b = 0; b < NBEAMS; b++) cnt_q[b] <= '0;
        end else begin
            timer_q <= (!enable_i || gate_end) ? '0 : timer_q + PERIOD_BITS'(1);
            prev_q  <= !enable_i ? '0 : trig_tvalid ? cur : prev_q;
            for (int b = 0; b < NBEAMS; b++) cnt_q[b] <= (!enable_i || gate_end) ? '0 : cnt_inc[b];
        end
    end

    // Readout next state; a gate end is taken only when idle or on the final handshake
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last        = idx_q == LAST_IDX;
        fin_hs      = state_q == SEND && scal_tready && last;
        load        = gate_end && (state_q == IDLE || fin_hs);
        ovr_set     = gate_end && !load;
        if (load) begin
            state_d = SEND;
            idx_d   = '0;
        end else if (state_q == SEND && scal_tready) begin
            state_d = last ? IDLE : SEND;
            idx_d   = last ? '0 : idx_q + IW'(1);
        end
        scal_tvalid = state_q == SEND;
        scal_tlast  = scal_tvalid && last;
        scal_tdata  = {8'(idx_q), 24'(hold_q[idx_q])};
    end

    // Readout state, beat index and sticky overrun (set beats clear)
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= ovr_set ? 1'b1 : overrun_clr_i ? 1'b0 : overrun_q;
        end
    end

    // Holding array captures the finished gate only when the readout accepts it
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            for (int b = 0; b < NBEAMS; b++) hold_q[b] <= '0;
        end else if (load) begin
            for (int b = 0; b < NBEAMS; b++) hold_q[b] <= cnt_inc[b];
        end
    end
endmodule

// File: tb/tb_beam_trigger_scaler.sv
// tb_beam_trigger_scaler: directed and random stimulus against a queue-based readout model
module tb_beam_trigger_scaler;
    localparam int NB = 14;
    localparam int CB = 4;
    localparam int PB = 27;
    localparam int SAT = (1 << CB) - 1;

    logic          aclk = 1'b0;
    logic          reset_i = 1'b0;
    logic [127:0]  trig_tdata = '0;
    logic          trig_tvalid = 1'b0;
    logic          enable_i = 1'b0;
    logic [PB-1:0] period_i = 27'd99;
    logic          overrun_clr_i = 1'b0;
    logic [31:0]   scal_tdata;
    logic          scal_tvalid;
    logic          scal_tready = 1'b1;
    logic          scal_tlast;
    logic          overrun_o;

    int vec = 0;
    int errs = 0;

    beam_trigger_scaler #(.NBEAMS(NB), .CNT_BITS(CB), .PERIOD_BITS(PB)) dut (
        .aclk(aclk), .reset_i(reset_i), .trig_tdata(trig_tdata), .trig_tvalid(trig_tvalid),
        .enable_i(enable_i), .period_i(period_i), .overrun_clr_i(overrun_clr_i),
        .scal_tdata(scal_tdata), .scal_tvalid(scal_tvalid), .scal_tready(scal_tready),
        .scal_tlast(scal_tlast), .overrun_o(overrun_o)
    );

    always #5 aclk = ~aclk;

    // Reference model: per-gate edge tallies, pending readout kept as a queue of expected beats
    int           m_cnt [NB];
    bit           m_prev [NB];
    int           m_timer, m_sz;
    bit           m_ov, m_gend, m_fin, m_cur;
    logic [127:0] m_td;
    logic [31:0]  rq [$];

    task automatic m_clear();
        for (int b = 0; b < NB; b++) begin
            m_cnt[b] = 0;
            m_prev[b] = 0;
        end
        m_timer = 0;
        m_ov = 0;
        rq.delete();
    endtask

    always @(posedge aclk or posedge reset_i) begin
        if (reset_i) m_clear();
        else begin
            m_sz = rq.size();
            m_fin = m_sz == 1 && scal_tready;
            m_gend = enable_i && m_timer >= int'(period_i);
            if (enable_i && trig_tvalid) begin
                m_td = trig_tdata;
                for (int b = 0; b < NB; b++) begin
                    m_cur = m_td[16*(b/12) + 4 + (b%12)];
                    if (m_cur && !m_prev[b]) m_cnt[b]++;
                    m_prev[b] = m_cur;
                end
            end
            if (m_sz != 0 && scal_tready) void'(rq.pop_front());
            if (m_gend && m_sz != 0 && !m_fin) m_ov = 1;
            else if (overrun_clr_i) m_ov = 0;
            if (m_gend && (m_sz == 0 || m_fin))
                for (int b = 0; b < NB; b++) rq.push_back({8'(b), 24'(m_cnt[b] > SAT ? SAT : m_cnt[b])});
            if (!enable_i) begin
                m_timer = 0;
                for (int b = 0; b < NB; b++) begin
                    m_cnt[b] = 0;
                    m_prev[b] = 0;
                end
            end else if (m_gend) begin
                m_timer = 0;
                for (int b = 0; b < NB; b++) m_cnt[b] = 0;
            end else m_timer++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        @(negedge aclk);
        chk("tvalid", 32'(scal_tvalid), 32'(rq.size() != 0));
        if (rq.size() != 0) begin
            chk("tdata", scal_tdata, rq[0]);
            chk("tlast", 32'(scal_tlast), 32'(rq.size() == 1));
        end
        chk("overrun", 32'(overrun_o), 32'(m_ov));
    endtask

    task automatic do_reset();
        enable_i = 0;
        trig_tvalid = 0;
        trig_tdata = '0;
        overrun_clr_i = 0;
        scal_tready = 1;
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] td;

    initial begin
        #1 reset_i = 1;
        #1;
        chk("rst_tvalid", 32'(scal_tvalid), 32'd0);
        chk("rst_tdata", scal_tdata, 32'd0);
        chk("rst_tlast", 32'(scal_tlast), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        do_reset();

        // Basic counting: beam0 pulse every 10 cycles, beam1 held high
        enable_i = 1; period_i = 27'd99; trig_tvalid = 1;
        for (int k = 0; k < 220; k++) begin
            td = '0; td[4] = (k % 10 == 0); td[5] = 1'b1; trig_tdata = td;
            tick();
            if (k == 99)  chk("t1_g1_b0", scal_tdata, 32'h0000000A);
            if (k == 100) chk("t1_g1_b1", scal_tdata, 32'h01000001);
            if (k == 199) chk("t1_g2_b0", scal_tdata, 32'h0000000A);
            if (k == 200) chk("t1_g2_b1", scal_tdata, 32'h01000000);
        end
        enable_i = 0;
        repeat (20) tick();

        // Backpressure: hold tready low for 50 cycles after gate end
        do_reset();
        enable_i = 1; period_i = 27'd99; trig_tvalid = 1;
        for (int k = 0; k < 180; k++) begin
            td = '0; td[4] = (k % 10 == 0); td[5] = 1'b1; trig_tdata = td;
            scal_tready = !(k >= 99 && k < 149);
            tick();
            if (k >= 99 && k < 149) chk("t2_stall", scal_tdata, 32'h0000000A);
        end
        chk("t2_no_ovr", 32'(overrun_o), 32'd0);
        enable_i = 0; scal_tready = 1;
        repeat (20) tick();

        // Overrun: short gate with the readout stalled
        do_reset();
        enable_i = 1; period_i = 27'd3; trig_tvalid = 1; scal_tready = 0;
        for (int k = 0; k < 8; k++) begin
            trig_tdata = rnd128() & rnd128();
            tick();
        end
        chk("t3_ovr_set", 32'(overrun_o), 32'd1);
        overrun_clr_i = 1;
        tick();
        chk("t3_ovr_clr", 32'(overrun_o), 32'd0);
        overrun_clr_i = 0; enable_i = 0; scal_tready = 1;
        repeat (20) tick();

        // Saturation: 20 edges on beam 2
        do_reset();
        enable_i = 1; period_i = 27'd99; trig_tvalid = 1;
        for (int k = 0; k < 120; k++) begin
            td = '0; td[6] = (k < 40 && k % 2 == 0); trig_tdata = td;
            tick();
            if (k == 101) chk("t4_sat", scal_tdata, 32'h0200000F);
        end
        enable_i = 0;
        repeat (20) tick();

        // Beam 13 mapping, tvalid gating, and lane low-nibble bits ignored
        do_reset();
        enable_i = 1; period_i = 27'd99;
        for (int k = 0; k < 120; k++) begin
            td = '0;
            td[21] = (k < 40 && k % 2 == 0);
            if (k >= 40 && k < 80 && k % 2 == 0) td = {8{16'h000F}};
            trig_tdata = td;
            trig_tvalid = (k % 4 != 2);
            tick();
            if (k == 112) chk("t5_beam13", scal_tdata, 32'h0D00000A);
        end
        enable_i = 0; trig_tvalid = 1;
        repeat (20) tick();

        // Reset during beat idx 1
        do_reset();
        enable_i = 1; period_i = 27'd19; trig_tvalid = 1;
        for (int k = 0; k < 21; k++) begin
            trig_tdata = rnd128() & rnd128();
            tick();
        end
        chk("t6_mid_idx", 32'(scal_tdata[31:24]), 32'd1);
        #2 reset_i = 1;
        #1 chk("t6_async_drop", 32'(scal_tvalid), 32'd0);
        tick();
        reset_i = 0;
        for (int k = 0; k < 40; k++) begin
            trig_tdata = rnd128() & rnd128();
            tick();
        end
        enable_i = 0;
        repeat (20) tick();

        // Random traffic with period changes, disable bursts, backpressure and overrun clears
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) period_i = PB'($urandom_range(40, 10));
            enable_i = (k % 500) >= 6;
            trig_tdata = rnd128() & rnd128() & rnd128();
            trig_tvalid = $urandom_range(3, 0) != 0;
            scal_tready = $urandom_range(3, 0) != 0;
            overrun_clr_i = $urandom_range(19, 0) == 0;
            tick();
        end
        enable_i = 0; scal_tready = 1; overrun_clr_i = 0;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
